spi_reg_bank: RTL and testbench
===============================

// Module: spi_reg_bank
// PURPOSE
//  SPI mode-0 target that decodes 16-bit write frames and holds the five 8-bit control
//  registers consumed by pwm_peripheral (output enables, PWM enables, duty cycle).
//  Sits directly upstream of pwm_peripheral in the tile top. SCLK/COPI/nCS arrive
//  asynchronously on ui_in[0..2] and are resynchronised into clk.
// PARAMETERS
//  SYNC_STAGES  2  flops per input synchroniser (legal range >=2)
//  MAX_ADDR     4  highest valid register address; writes above it are dropped
// PORTS
//  clk              in   1  system clock; must be >= 8x sclk frequency
//  rst              in   1  asynchronous, active-high reset
//  sclk             in   1  SPI clock, async to clk
//  copi             in   1  SPI data in, async
//  ncs              in   1  SPI chip select, active-low, async
//  cipo             out  1  SPI data out (readback only, else 0)
//  en_reg_out_7_0   out  8  addr 0x00
//  en_reg_out_15_8  out  8  addr 0x01
//  en_reg_pwm_7_0   out  8  addr 0x02
//  en_reg_pwm_15_8  out  8  addr 0x03
//  pwm_duty_cycle   out  8  addr 0x04
//  wr_strobe        out  1  1-clk pulse when a register commits
// BEHAVIOUR
//  - sclk/copi/ncs each pass SYNC_STAGES flops + one history flop for edge detect.
//  - Frame = 16 bits MSB first: [15] R/nW (1=write), [14:8] addr, [7:0] data.
//  - Synced ncs falling edge: bit_cnt<=0, shift reg cleared, frame active.
//  - While active, each synced sclk rising edge: shift in synced copi; bit_cnt+1,
//    saturating at 17 (17 = overflow).
//  - Synced ncs rising edge: commit iff bit_cnt==16 AND bit[15]==1 AND addr<=MAX_ADDR.
//    Register updated on that same clk edge; wr_strobe high exactly that cycle.
//    Raw ncs rise -> outputs valid after SYNC_STAGES+2 clk edges.
//  - Short (<16), overflowed (17), read, or out-of-range frames: no register change,
//    no wr_strobe.
//  - sclk edges while ncs high are ignored; ncs fall and rise in the same synced
//    sample cannot occur (single flop).
//  - States: IDLE -> (ncs fall) SHIFT -> (ncs rise) COMMIT (1 cycle) -> IDLE.
//  - rst: all five registers 0x00, wr_strobe 0, cipo 0, bit_cnt 0, synchronisers 0
//    except ncs chain reset to 1; state IDLE. Reset mid-frame aborts the frame.
// CONFIGURATION
//  SPI_READBACK_EN defined: frames with bit[15]==0 are reads. After the 8th bit
//  (addr complete), the addressed register (0x00 if addr>MAX_ADDR) loads a tx shift
//  reg; cipo presents its MSB, then advances on each synced sclk falling edge for
//  bits 9..16. cipo forced 0 whenever synced ncs is high.
//  Undefined: cipo tied 0, read frames silently discarded, no tx logic synthesised.
// STRUCTURE
//  Package spi_reg_pkg: FRAME_W=16, ADDR_W=7, DATA_W=8, localparams
//  ADDR_EN_OUT_LO/HI, ADDR_EN_PWM_LO/HI, ADDR_DUTY, state enum.
//  Sub-module sync_edge_det (SYNC_STAGES synchroniser + rise/fall pulses, reset value
//  param), instantiated for sclk, copi, ncs.
// TESTING
//  1 write 0x80_01 (addr0, data 0x01) -> en_reg_out_7_0=0x01, one wr_strobe, others 0.
//  2 write 0x84_80 -> pwm_duty_cycle=0x80; then 0x85_FF -> no change, no strobe.
//  3 15-bit frame 0x82_F (ncs rises early) and 17-bit frame -> en_reg_pwm_7_0 stays 0.
//  4 assert rst after 9 bits of 0x83_AA, release, send 0x83_55 -> en_reg_pwm_15_8=0x55.
//  5 back-to-back writes addr0..4 data 0x11..0x55, 2 clk ncs high gap -> all five set.
//  6 SPI_READBACK_EN: after test 5, read 0x04_00 -> cipo shifts 0x55 MSB first; regs
//    unchanged; without macro cipo stays 0.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared frame geometry, register map and FSM state type for the SPI register bank.
package spi_reg_pkg;

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned ADDR_W  = 7;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned CNT_W   = 5;

  // Bit counter values: a full frame, and the saturating overflow marker
  localparam logic [CNT_W-1:0] CNT_FULL = 5'd16;
  localparam logic [CNT_W-1:0] CNT_OVF  = 5'd17;

  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_DUTY      = 7'h04;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser with one history flop and registered rise/fall pulses.
// level, rise and fall are mutually aligned (all change on the same clk edge).
module sync_edge_det #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              hist;

  // Resynchronise din and derive single-cycle edge pulses from the settled sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {STAGES{RST_VAL}};
      hist  <= RST_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      hist  <= chain[STAGES-1];
      rise  <= chain[STAGES-1] & ~hist;
      fall  <= ~chain[STAGES-1] & hist;
    end
  end

  assign level = hist;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 target holding the five pwm_peripheral control registers.
// Optional feature macro: SPI_READBACK_EN (read frames shift register data out on cipo).
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_ADDR    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              copi,
  input  logic              ncs,
  output logic              cipo,
  output logic [DATA_W-1:0] en_reg_out_7_0,
  output logic [DATA_W-1:0] en_reg_out_15_8,
  output logic [DATA_W-1:0] en_reg_pwm_7_0,
  output logic [DATA_W-1:0] en_reg_pwm_15_8,
  output logic [DATA_W-1:0] pwm_duty_cycle,
  output logic              wr_strobe
);

  localparam logic [ADDR_W-1:0] MAX_ADDR_V = ADDR_W'(MAX_ADDR);

  logic sclk_s, sclk_rise, sclk_fall;
  logic copi_s, copi_rise, copi_fall;
  logic ncs_s, ncs_rise, ncs_fall;

  state_t             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [FRAME_W-1:0] shreg;
  logic [FRAME_W-1:0] shreg_nxt;
  logic [ADDR_W-1:0]  frame_addr;
  logic [DATA_W-1:0]  frame_data;
  logic               frame_ok;

  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(sclk), .level(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .din(copi), .level(copi_s), .rise(copi_rise), .fall(copi_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst(rst), .din(ncs), .level(ncs_s), .rise(ncs_rise), .fall(ncs_fall)
  );

  assign shreg_nxt  = {shreg[FRAME_W-2:0], copi_s};
  assign frame_addr = shreg[FRAME_W-2:DATA_W];
  assign frame_data = shreg[DATA_W-1:0];
  assign frame_ok   = (bit_cnt == CNT_FULL) && shreg[FRAME_W-1] && (frame_addr <= MAX_ADDR_V);

  // Frame FSM: collect bits while selected, commit a valid write on deselect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      bit_cnt         <= '0;
      shreg           <= '0;
      wr_strobe       <= 1'b0;
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
    end else begin
      wr_strobe <= 1'b0;
      case (state)
        ST_IDLE, ST_COMMIT: begin
          state <= ST_IDLE;
          if (ncs_fall) begin
            bit_cnt <= '0;
            shreg   <= '0;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (ncs_rise) begin
            state <= ST_COMMIT;
            if (frame_ok) begin
              wr_strobe <= 1'b1;
              case (frame_addr)
                ADDR_EN_OUT_LO: en_reg_out_7_0  <= frame_data;
                ADDR_EN_OUT_HI: en_reg_out_15_8 <= frame_data;
                ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= frame_data;
                ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= frame_data;
                ADDR_DUTY:      pwm_duty_cycle  <= frame_data;
                default:        ;
              endcase
            end
          end else if (sclk_rise) begin
            shreg <= shreg_nxt;
            if (bit_cnt != CNT_OVF) begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SPI_READBACK_EN
  logic [DATA_W-1:0] tx_shreg;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] rd_addr;
  logic              unused_sync;

  assign rd_addr     = shreg_nxt[ADDR_W-1:0];
  assign unused_sync = ^{sclk_s, copi_rise, copi_fall};

  // Register read mux; out-of-range addresses read as zero
  always_comb begin
    rd_data = '0;
    if (rd_addr <= MAX_ADDR_V) begin
      case (rd_addr)
        ADDR_EN_OUT_LO: rd_data = en_reg_out_7_0;
        ADDR_EN_OUT_HI: rd_data = en_reg_out_15_8;
        ADDR_EN_PWM_LO: rd_data = en_reg_pwm_7_0;
        ADDR_EN_PWM_HI: rd_data = en_reg_pwm_15_8;
        ADDR_DUTY:      rd_data = pwm_duty_cycle;
        default:        rd_data = '0;
      endcase
    end
  end

  // Load on the 8th rising edge; the falling edge right after it is skipped so
  // the MSB is held for the controller's 9th sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shreg <= '0;
    end else if (state == ST_SHIFT && !ncs_rise) begin
      if (sclk_rise && bit_cnt == CNT_W'(7)) begin
        tx_shreg <= shreg_nxt[DATA_W-1] ? '0 : rd_data;
      end else if (sclk_fall && bit_cnt >= CNT_W'(9)) begin
        tx_shreg <= {tx_shreg[DATA_W-2:0], 1'b0};
      end
    end else if (ncs_fall) begin
      tx_shreg <= '0;
    end
  end

  assign cipo = ~ncs_s & tx_shreg[DATA_W-1];
`else
  logic unused_sync;

  assign unused_sync = ^{sclk_s, sclk_fall, copi_rise, copi_fall, ncs_s};
  assign cipo        = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank; readback expectations follow SPI_READBACK_EN.
module tb_spi_reg_bank;

  localparam time CLK_HALF  = 5;
  localparam time SCLK_HALF = 80;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic       cipo;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       wr_strobe;

  int unsigned n_checks   = 0;
  int unsigned n_bad      = 0;
  int unsigned strobe_cnt = 0;
  int unsigned s0;
  logic [7:0]  rx;
  logic [7:0]  rd_exp;

  spi_reg_bank #(.SYNC_STAGES(2), .MAX_ADDR(4)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .wr_strobe(wr_strobe)
  );

  always #(CLK_HALF) clk = ~clk;

  // Count clk cycles with wr_strobe high
  always @(negedge clk) begin
    if (wr_strobe) strobe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Mode-0 controller: copi set while sclk low, sampled by target on rising edge;
  // cipo captured just before rising edges 9..16
  task automatic spi_xfer(input logic [31:0] frame, input int unsigned nbits,
                          output logic [7:0] rx_byte);
    rx_byte = '0;
    ncs = 1'b0;
    #(SCLK_HALF);
    for (int unsigned i = 0; i < nbits; i++) begin
      copi = frame[nbits-1-i];
      #(SCLK_HALF);
      if (i >= 8 && i < 16) rx_byte = {rx_byte[6:0], cipo};
      sclk = 1'b1;
      #(SCLK_HALF);
      sclk = 1'b0;
    end
    copi = 1'b0;
    #(SCLK_HALF);
    ncs = 1'b1;
  endtask

  task automatic settle();
    repeat (10) @(negedge clk);
  endtask

  initial begin
    rst  = 1'b1;
    sclk = 1'b0;
    copi = 1'b0;
    ncs  = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_out_lo", en_reg_out_7_0, 8'h00);
    check("rst_out_hi", en_reg_out_15_8, 8'h00);
    check("rst_pwm_lo", en_reg_pwm_7_0, 8'h00);
    check("rst_pwm_hi", en_reg_pwm_15_8, 8'h00);
    check("rst_duty", pwm_duty_cycle, 8'h00);
    check("rst_strobe", wr_strobe, 1'b0);
    check("rst_cipo", cipo, 1'b0);

    // 1: write addr0 = 0x01
    s0 = strobe_cnt;
    spi_xfer(32'h8001, 16, rx);
    settle();
    check("t1_out_lo", en_reg_out_7_0, 8'h01);
    check("t1_strobes", strobe_cnt - s0, 1);
    check("t1_out_hi", en_reg_out_15_8, 8'h00);
    check("t1_pwm_lo", en_reg_pwm_7_0, 8'h00);
    check("t1_pwm_hi", en_reg_pwm_15_8, 8'h00);
    check("t1_duty", pwm_duty_cycle, 8'h00);
    check("t1_cipo", cipo, 1'b0);

    // 2: highest valid address, then one past it
    s0 = strobe_cnt;
    spi_xfer(32'h8480, 16, rx);
    settle();
    check("t2_duty", pwm_duty_cycle, 8'h80);
    check("t2_strobes", strobe_cnt - s0, 1);
    s0 = strobe_cnt;
    spi_xfer(32'h85FF, 16, rx);
    settle();
    check("t2_oor_duty", pwm_duty_cycle, 8'h80);
    check("t2_oor_strobes", strobe_cnt - s0, 0);

    // 3: short (15-bit) and overflowed (17-bit) frames to addr2
    s0 = strobe_cnt;
    spi_xfer(32'h0000_417F, 15, rx);
    settle();
    check("t3_short_pwm_lo", en_reg_pwm_7_0, 8'h00);
    spi_xfer(32'h0001_05FF, 17, rx);
    settle();
    check("t3_ovf_pwm_lo", en_reg_pwm_7_0, 8'h00);
    check("t3_strobes", strobe_cnt - s0, 0);

    // 4: reset after 9 bits of 0x83AA, then a clean 0x8355
    ncs = 1'b0;
    #(SCLK_HALF);
    for (int unsigned i = 0; i < 9; i++) begin
      copi = (i == 0 || i == 6 || i == 7 || i == 8);
      #(SCLK_HALF);
      sclk = 1'b1;
      #(SCLK_HALF);
      sclk = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    ncs = 1'b1;
    copi = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    settle();
    check("t4_rst_duty", pwm_duty_cycle, 8'h00);
    check("t4_rst_out_lo", en_reg_out_7_0, 8'h00);
    check("t4_rst_pwm_hi", en_reg_pwm_15_8, 8'h00);
    s0 = strobe_cnt;
    spi_xfer(32'h8355, 16, rx);
    settle();
    check("t4_pwm_hi", en_reg_pwm_15_8, 8'h55);
    check("t4_strobes", strobe_cnt - s0, 1);

    // 5: back-to-back writes with a 2-clk deselect gap
    s0 = strobe_cnt;
    for (int unsigned a = 0; a < 5; a++) begin
      spi_xfer(32'h8000 | (a << 8) | ((a + 1) * 8'h11), 16, rx);
      #(2 * 2 * CLK_HALF);
    end
    settle();
    check("t5_out_lo", en_reg_out_7_0, 8'h11);
    check("t5_out_hi", en_reg_out_15_8, 8'h22);
    check("t5_pwm_lo", en_reg_pwm_7_0, 8'h33);
    check("t5_pwm_hi", en_reg_pwm_15_8, 8'h44);
    check("t5_duty", pwm_duty_cycle, 8'h55);
    check("t5_strobes", strobe_cnt - s0, 5);

    // 6: read addr4
`ifdef SPI_READBACK_EN
    rd_exp = 8'h55;
`else
    rd_exp = 8'h00;
`endif
    s0 = strobe_cnt;
    spi_xfer(32'h0400, 16, rx);
    settle();
    check("t6_rx", rx, rd_exp);
    check("t6_strobes", strobe_cnt - s0, 0);
    check("t6_duty", pwm_duty_cycle, 8'h55);
    check("t6_out_lo", en_reg_out_7_0, 8'h11);
    check("t6_cipo_idle", cipo, 1'b0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
